// File: rtl/reg_shift_seq_if.sv
// reg_shift_seq_if: request/response bundle for the multi-cycle shift unit.
interface reg_shift_seq_if #(
    parameter int W  = 8,
    parameter int SW = 4
);
    logic          start;
    logic [2:0]    mode;
    logic [SW-1:0] amount;
    logic [W-1:0]  data;
    logic          input_left;
    logic          input_right;
    logic [W-1:0]  out;
    logic          busy;
    logic          done;
    logic          carry_out;

    modport master (
        output start, mode, amount, data, input_left, input_right,
        input  out, busy, done, carry_out
    );

    modport slave (
        input  start, mode, amount, data, input_left, input_right,
        output out, busy, done, carry_out
    );
endinterface

// File: rtl/reg_shift_seq.sv
// reg_shift_seq: universal shift register stepping one bit position per clock.
module reg_shift_seq #(
    parameter int W  = 8,
    parameter int SW = 4
) (
    input logic             clk,
    input logic             reset,
    reg_shift_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  out_q, out_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [2:0]    mode_q, mode_d;
    logic          carry_q, carry_d;
    logic [2:0]    m;
    logic          shift_m;
    logic [W:0]    st;

    always_comb begin
        m = (state_q == IDLE) ? bus.mode : mode_q;
        case (m)
            3'b010:  st = {out_q[W-1], out_q[W-2:0], bus.input_right};
            3'b011:  st = {out_q[0], bus.input_left, out_q[W-1:1]};
            3'b100:  st = {out_q[0], out_q[W-1], out_q[W-1:1]};
            3'b101:  st = {out_q[W-1], out_q[W-2:0], out_q[W-1]};
            3'b110:  st = {out_q[0], out_q[0], out_q[W-1:1]};
            default: st = {carry_q, out_q};
        endcase
        shift_m = m inside {[3'b010:3'b110]};
        state_d = state_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        carry_d = carry_q;
        if (state_q == IDLE && bus.start) begin
            mode_d  = bus.mode;
            state_d = DONE;
            if (m == 3'b001)
                out_d = bus.data;
            else if (shift_m && bus.amount != '0) begin
                // First step happens on the accepting edge itself.
                {carry_d, out_d} = st;
                cnt_d = bus.amount - 1'b1;
                if (bus.amount != SW'(1))
                    state_d = SHIFT;
            end
        end else if (state_q == SHIFT) begin
            {carry_d, out_d} = st;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == SW'(1))
                state_d = DONE;
        end else if (state_q == DONE)
            state_d = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            out_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.carry_out = carry_q;
    assign bus.busy      = state_q != IDLE;
    assign bus.done      = state_q == DONE;
endmodule

// File: tb/tb_reg_shift_seq.sv
// tb_reg_shift_seq: directed scenarios for reg_shift_seq with hand-computed results.
module tb_reg_shift_seq;
    localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, SLL = 3'b010, SRL = 3'b011;
    localparam logic [2:0] SRA = 3'b100, ROL = 3'b101, ROR = 3'b110, RSV = 3'b111;

    logic clk = 0;
    logic reset = 1;
    int n_cmp = 0;
    int n_err = 0;

    reg_shift_seq_if #(.W(8), .SW(4)) bus();
    reg_shift_seq #(.W(8), .SW(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic run_op(input logic [2:0] m, input logic [3:0] a, input logic [7:0] d, output int cyc);
        @(negedge clk);
        bus.start = 1; bus.mode = m; bus.amount = a; bus.data = d;
        @(negedge clk);
        bus.start = 0;
        cyc = 1;
        while (!bus.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        int cyc;
        @(negedge clk);
        n_cmp++; if (bus.out !== 8'h00) begin n_err++; $display("FAIL por_out: got %h want 00", bus.out); end
        n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.carry_out !== 1'b0) begin n_err++; $display("FAIL por_flags: busy %b done %b carry %b want 000", bus.busy, bus.done, bus.carry_out); end
        reset = 0;
        run_op(LOAD, 4'd0, 8'hAA, cyc);
        bus.input_right = 0;
        @(negedge clk);
        bus.start = 1; bus.mode = SLL; bus.amount = 4'd5;
        @(negedge clk);
        bus.start = 0;
        @(negedge clk);
        n_cmp++; if (bus.out !== 8'hA8 || bus.busy !== 1'b1) begin n_err++; $display("FAIL mid_shift: got out %h busy %b want A8 1", bus.out, bus.busy); end
        #2 reset = 1;
        #1;
        n_cmp++; if (bus.out !== 8'h00) begin n_err++; $display("FAIL async_rst_out: got %h want 00", bus.out); end
        n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_err++; $display("FAIL async_rst_flags: busy %b done %b want 0 0", bus.busy, bus.done); end
        #1 reset = 0;
        run_op(LOAD, 4'd0, 8'h12, cyc);
        n_cmp++; if (cyc !== 1 || bus.out !== 8'h12) begin n_err++; $display("FAIL post_rst_load: cyc %0d out %h want 1 12", cyc, bus.out); end
    endtask

    task automatic test_rol;
        int cyc;
        run_op(LOAD, 4'd0, 8'h81, cyc);
        run_op(ROL, 4'd1, 8'h00, cyc);
        n_cmp++; if (cyc !== 1 || bus.busy !== 1'b1) begin n_err++; $display("FAIL rol_lat: cyc %0d busy %b want 1 1", cyc, bus.busy); end
        n_cmp++; if (bus.out !== 8'h03 || bus.carry_out !== 1'b1) begin n_err++; $display("FAIL rol_out: got %h c%b want 03 c1", bus.out, bus.carry_out); end
        @(negedge clk);
        n_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL rol_pulse: done %b busy %b want 0 0", bus.done, bus.busy); end
    endtask

    task automatic test_sra;
        int cyc;
        run_op(LOAD, 4'd0, 8'h90, cyc);
        run_op(SRA, 4'd3, 8'h00, cyc);
        n_cmp++; if (cyc !== 3) begin n_err++; $display("FAIL sra_lat: got %0d want 3", cyc); end
        n_cmp++; if (bus.out !== 8'hF2 || bus.carry_out !== 1'b0) begin n_err++; $display("FAIL sra_out: got %h c%b want F2 c0", bus.out, bus.carry_out); end
    endtask

    task automatic test_sll;
        int cyc;
        run_op(LOAD, 4'd0, 8'h0F, cyc);
        bus.input_right = 1;
        run_op(SLL, 4'd4, 8'h00, cyc);
        n_cmp++; if (cyc !== 4 || bus.out !== 8'hFF || bus.carry_out !== 1'b0) begin n_err++; $display("FAIL sll_held: cyc %0d out %h c%b want 4 FF c0", cyc, bus.out, bus.carry_out); end
        run_op(LOAD, 4'd0, 8'h0F, cyc);
        @(negedge clk);
        bus.start = 1; bus.mode = SLL; bus.amount = 4'd4; bus.input_right = 1;
        @(negedge clk);
        bus.start = 0; bus.input_right = 0;
        @(negedge clk);
        bus.input_right = 1;
        @(negedge clk);
        bus.input_right = 0;
        @(negedge clk);
        n_cmp++; if (bus.done !== 1'b1 || bus.out !== 8'hFA) begin n_err++; $display("FAIL sll_toggle: done %b out %h want 1 FA", bus.done, bus.out); end
    endtask

    task automatic test_ror_ignore;
        int cyc;
        run_op(LOAD, 4'd0, 8'h01, cyc);
        @(negedge clk);
        bus.start = 1; bus.mode = ROR; bus.amount = 4'd9;
        @(negedge clk);
        bus.mode = LOAD; bus.data = 8'h55;
        @(negedge clk);
        bus.start = 0;
        cyc = 2;
        while (!bus.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if (cyc !== 9) begin n_err++; $display("FAIL ror_lat: got %0d want 9", cyc); end
        n_cmp++; if (bus.out !== 8'h80 || bus.carry_out !== 1'b1) begin n_err++; $display("FAIL ror_out: got %h c%b want 80 c1", bus.out, bus.carry_out); end
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0 || bus.out !== 8'h80) begin n_err++; $display("FAIL ror_noqueue: busy %b out %h want 0 80", bus.busy, bus.out); end
    endtask

    task automatic test_zero_and_reserved;
        int cyc;
        run_op(LOAD, 4'd0, 8'h3C, cyc);
        run_op(SRL, 4'd0, 8'h00, cyc);
        n_cmp++; if (cyc !== 1 || bus.out !== 8'h3C) begin n_err++; $display("FAIL srl0: cyc %0d out %h want 1 3C", cyc, bus.out); end
        run_op(RSV, 4'd3, 8'hFF, cyc);
        n_cmp++; if (cyc !== 1 || bus.out !== 8'h3C) begin n_err++; $display("FAIL rsv: cyc %0d out %h want 1 3C", cyc, bus.out); end
        @(negedge clk);
        n_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL rsv_pulse: done %b busy %b want 0 0", bus.done, bus.busy); end
        run_op(HOLD, 4'd2, 8'hFF, cyc);
        n_cmp++; if (cyc !== 1 || bus.out !== 8'h3C) begin n_err++; $display("FAIL hold: cyc %0d out %h want 1 3C", cyc, bus.out); end
    endtask

    initial begin
        bus.start = 0; bus.mode = HOLD; bus.amount = 0; bus.data = 0;
        bus.input_left = 0; bus.input_right = 0;
        test_reset;
        test_rol;
        test_sra;
        test_sll;
        test_ror_ignore;
        test_zero_and_reserved;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
